pcpi_lut_mul_ctrl: RTL and testbench

Sequential PCPI co-processor front-end for the LUT-based 32x32 multiplier, which is combinational and unsigned. It accepts RV32M MUL/MULH/MULHSU/MULHU instructions from the core's PCPI port and converts signed operands to magnitudes. It drives the multiplier, waits a programmable settle time, restores the sign of the 64-bit product, and returns the selected 32-bit half with a one-cycle ready/write pulse.

---
 rtl/pcpi_lut_mul_ctrl.sv | 126 ++++++++++++
 tb/tb_pcpi_lut_mul_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pcpi_lut_mul_ctrl.sv
// pcpi_lut_mul_ctrl
//   PCPI front-end for an external combinational, unsigned 32x32 LUT multiplier.
//   It accepts RV32M MUL/MULH/MULHSU/MULHU, hands operand magnitudes to the
//   multiplier, waits MUL_WAIT cycles for the product to settle, restores the
//   product's sign and returns the selected 32-bit half with a one-cycle
//   ready/write pulse.
//
// Ports
//   clk_i, resetn_i      clock, asynchronous active-low reset
//   pcpi_valid_i         instruction presented (held until ready)
//   pcpi_insn_i          instruction word
//   pcpi_rs1_i/rs2_i     source operands
//   pcpi_wr_o            write rd (pulses with ready)
//   pcpi_rd_o            result, zero unless ready is high
//   pcpi_wait_o          busy (any state other than IDLE)
//   pcpi_ready_o         one-cycle completion pulse
//   mul_a_o/mul_b_o      unsigned operand magnitudes to the multiplier
//   mul_resetn_o         multiplier enable; its product reads 0 while low
//   mul_r_i              unsigned 64-bit product from the multiplier
module pcpi_lut_mul_ctrl #(
    parameter int unsigned MUL_WAIT = 1  // settle cycles, 1..15
) (
    input  logic        clk_i,
    input  logic        resetn_i,
    input  logic        pcpi_valid_i,
    input  logic [31:0] pcpi_insn_i,
    input  logic [31:0] pcpi_rs1_i,
    input  logic [31:0] pcpi_rs2_i,
    output logic        pcpi_wr_o,
    output logic [31:0] pcpi_rd_o,
    output logic        pcpi_wait_o,
    output logic        pcpi_ready_o,
    output logic [31:0] mul_a_o,
    output logic [31:0] mul_b_o,
    output logic        mul_resetn_o,
    input  logic [63:0] mul_r_i
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FIX, S_DONE} state_t;

    localparam logic [3:0] WAIT_INIT = 4'(MUL_WAIT);

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] mul_a_q, mul_b_q;
    logic        neg_q;
    logic        lo_q;     // 1: return low word (MUL)
    logic [63:0] prod_q;

    // Instruction decode
    logic [2:0]  funct3;
    logic        match_d, s1_d, s2_d, neg_d;
    logic [31:0] mag1_d, mag2_d;
    logic [63:0] prod_d;
    logic        unused_insn;

    assign funct3  = pcpi_insn_i[14:12];
    assign match_d = (pcpi_insn_i[6:0] == 7'b0110011) &&
                     (pcpi_insn_i[31:25] == 7'b0000001) &&
                     !funct3[2];
    assign s1_d    = (funct3 == 3'b001) || (funct3 == 3'b010);
    assign s2_d    = (funct3 == 3'b001);
    assign neg_d   = (s1_d & pcpi_rs1_i[31]) ^ (s2_d & pcpi_rs2_i[31]);
    // 0x80000000 negates to itself, which is exactly 2^31 read unsigned.
    assign mag1_d  = (s1_d && pcpi_rs1_i[31]) ? -pcpi_rs1_i : pcpi_rs1_i;
    assign mag2_d  = (s2_d && pcpi_rs2_i[31]) ? -pcpi_rs2_i : pcpi_rs2_i;
    assign prod_d  = neg_q ? (~mul_r_i + 64'd1) : mul_r_i;

    // Register fields are irrelevant to the co-processor.
    assign unused_insn = ^{pcpi_insn_i[24:15], pcpi_insn_i[11:7]};

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mul_a_q <= '0;
            mul_b_q <= '0;
            neg_q   <= 1'b0;
            lo_q    <= 1'b0;
            prod_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pcpi_valid_i && match_d) begin
                        state_q <= S_WAIT;
                        mul_a_q <= mag1_d;
                        mul_b_q <= mag2_d;
                        neg_q   <= neg_d;
                        lo_q    <= (funct3 == 3'b000);
                        cnt_q   <= WAIT_INIT;
                    end
                end
                S_WAIT: begin
                    if (!pcpi_valid_i) begin
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                        // Last settle cycle: the product is sampled in FIX.
                        if (cnt_q == 4'd1) state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (!pcpi_valid_i) begin
                        state_q <= S_IDLE;
                    end else begin
                        prod_q  <= prod_d;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: state_q <= S_IDLE;  // completes even if valid dropped
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Outputs decode only from registered state.
    assign pcpi_ready_o = (state_q == S_DONE);
    assign pcpi_wr_o    = (state_q == S_DONE);
    assign pcpi_wait_o  = (state_q != S_IDLE);
    assign pcpi_rd_o    = (state_q != S_DONE) ? 32'd0 :
                          (lo_q ? prod_q[31:0] : prod_q[63:32]);
    assign mul_a_o      = mul_a_q;
    assign mul_b_o      = mul_b_q;
    assign mul_resetn_o = resetn_i & (state_q != S_IDLE);

endmodule

// File: tb/tb_pcpi_lut_mul_ctrl.sv
module tb_pcpi_lut_mul_ctrl;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        valid1 = 1'b0, valid3 = 1'b0;
    logic [31:0] insn = '0, rs1 = '0, rs2 = '0;

    logic        wr1, wait1, rdy1, mr1, wr3, wait3, rdy3, mr3;
    logic [31:0] rd1, a1, b1, rd3, a3, b3;
    logic [63:0] r1, r3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Behavioural multiplier: product of the magnitudes, zero while disabled.
    assign r1 = mr1 ? ({32'd0, a1} * {32'd0, b1}) : 64'd0;
    assign r3 = mr3 ? ({32'd0, a3} * {32'd0, b3}) : 64'd0;

    pcpi_lut_mul_ctrl #(.MUL_WAIT(1)) dut1 (
        .clk_i(clk), .resetn_i(resetn), .pcpi_valid_i(valid1), .pcpi_insn_i(insn),
        .pcpi_rs1_i(rs1), .pcpi_rs2_i(rs2), .pcpi_wr_o(wr1), .pcpi_rd_o(rd1),
        .pcpi_wait_o(wait1), .pcpi_ready_o(rdy1), .mul_a_o(a1), .mul_b_o(b1),
        .mul_resetn_o(mr1), .mul_r_i(r1));

    pcpi_lut_mul_ctrl #(.MUL_WAIT(3)) dut3 (
        .clk_i(clk), .resetn_i(resetn), .pcpi_valid_i(valid3), .pcpi_insn_i(insn),
        .pcpi_rs1_i(rs1), .pcpi_rs2_i(rs2), .pcpi_wr_o(wr3), .pcpi_rd_o(rd3),
        .pcpi_wait_o(wait3), .pcpi_ready_o(rdy3), .mul_a_o(a3), .mul_b_o(b3),
        .mul_resetn_o(mr3), .mul_r_i(r3));

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input bit ok, input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [2:0] f3);
        return {7'b0000001, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
    endfunction

    // Reference: full-width product of sign/zero-extended operands, mod 2^64.
    function automatic logic [31:0] refm(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] b);
        logic [63:0] xa, xb, p;
        xa = (f3 == 3'd1 || f3 == 3'd2) ? {{32{a[31]}}, a} : {32'd0, a};
        xb = (f3 == 3'd1) ? {{32{b[31]}}, b} : {32'd0, b};
        p  = xa * xb;
        return (f3 == 3'd0) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] absv(input bit sgn, input logic [31:0] x);
        return (sgn && x[31]) ? (32'd0 - x) : x;
    endfunction

    // Issue one instruction at a negedge and follow it to completion.
    task automatic run_op(input bit sel, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input string nm);
        int          w = sel ? 3 : 1;
        int          rdy_cnt = 0, rdy_at = -1;
        bit          wait_ok = 1'b1, wr_ok = 1'b1;
        logic [31:0] rd_seen = '0;
        logic [31:0] ea, eb;
        ea = absv(f3 == 3'd1 || f3 == 3'd2, a);
        eb = absv(f3 == 3'd1, b);
        insn = enc(f3); rs1 = a; rs2 = b;
        if (sel) valid3 = 1'b1; else valid1 = 1'b1;
        for (int k = 1; k <= w + 3; k++) begin
            @(posedge clk); @(negedge clk);
            if (k == 1)
                chk({(sel ? a3 : a1), (sel ? b3 : b1)} == {ea, eb}, {nm, "_mag"},
                    {(sel ? a3 : a1), (sel ? b3 : b1)}, {ea, eb});
            if (k <= w + 2 && !(sel ? wait3 : wait1)) wait_ok = 1'b0;
            if ((sel ? wr3 : wr1) != (sel ? rdy3 : rdy1)) wr_ok = 1'b0;
            if (sel ? rdy3 : rdy1) begin
                rdy_cnt++; rdy_at = k; rd_seen = sel ? rd3 : rd1;
            end
            if (k == w + 2) begin valid1 = 1'b0; valid3 = 1'b0; end
            if (k == w + 3)
                chk(!(sel ? wait3 : wait1) && (sel ? rd3 : rd1) == 32'd0, {nm, "_idle"},
                    {31'd0, (sel ? wait3 : wait1), (sel ? rd3 : rd1)}, 64'd0);
        end
        chk(rdy_cnt == 1 && rdy_at == w + 2, {nm, "_rdy_at"}, 64'(rdy_at), 64'(w + 2));
        chk(wait_ok && wr_ok, {nm, "_wait_wr"}, {wait_ok, wr_ok}, 64'd3);
        chk(rd_seen == exp, {nm, "_rd"}, rd_seen, exp);
    endtask

    initial begin
        int bad;
        logic [31:0] pool[6];
        logic [31:0] ra, rb;
        logic [2:0]  f;
        pool = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h80000001};

        tbl[0] = '{3'd0, 32'd7,         32'd6,         32'd42};
        tbl[1] = '{3'd1, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000000};
        tbl[2] = '{3'd3, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFE};
        tbl[3] = '{3'd2, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFF};
        tbl[4] = '{3'd0, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000001};
        tbl[5] = '{3'd1, 32'h80000000,  32'h80000000,  32'h40000000};
        tbl[6] = '{3'd0, 32'h80000000,  32'h80000000,  32'h00000000};
        tbl[7] = '{3'd2, 32'h80000000,  32'd2,         32'hFFFFFFFF};

        // Reset state
        #3;
        chk({wr1, rdy1, wait1, mr1} == 4'd0, "rst_ctl", {wr1, rdy1, wait1, mr1}, 0);
        chk(rd1 == 0, "rst_rd", rd1, 0);
        chk({a1, b1} == 64'd0, "rst_ab", {a1, b1}, 0);
        @(negedge clk); @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // Directed table
        foreach (tbl[i]) run_op(1'b0, tbl[i].f3, tbl[i].a, tbl[i].b, tbl[i].exp, $sformatf("tbl%0d", i));

        // Longer settle time
        run_op(1'b1, 3'd0, 32'h12345678, 32'h10, 32'h23456780, "w3_mul");

        // Non-matching word held valid
        insn = 32'h002081B3; rs1 = 32'd3; rs2 = 32'd4; valid1 = 1'b1; bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); @(negedge clk);
            if (wait1 || rdy1 || wr1 || mr1) bad++;
        end
        valid1 = 1'b0;
        chk(bad == 0, "add_ignored", 64'(bad), 0);

        // Abort by dropping valid in WAIT
        insn = enc(3'd0); rs1 = 32'd5; rs2 = 32'd9; valid1 = 1'b1;
        @(posedge clk); @(negedge clk);
        chk(wait1 == 1'b1, "abort_wait_hi", wait1, 1);
        valid1 = 1'b0;
        @(posedge clk); @(negedge clk);
        chk(wait1 == 1'b0, "abort_idle", wait1, 0);
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); @(negedge clk);
            if (rdy1 || wr1) bad++;
        end
        chk(bad == 0, "abort_no_rdy", 64'(bad), 0);
        run_op(1'b0, 3'd0, 32'd5, 32'd9, 32'd45, "after_abort");

        // Async reset mid-WAIT
        insn = enc(3'd0); rs1 = 32'd11; rs2 = 32'd13; valid1 = 1'b1;
        @(posedge clk); @(negedge clk);
        chk(wait1 == 1'b1, "arst_wait_hi", wait1, 1);
        #2 resetn = 1'b0;
        #1;
        chk({wr1, rdy1, wait1, mr1} == 4'd0 && rd1 == 0 && {a1, b1} == 64'd0, "arst_outs",
            {wr1, rdy1, wait1, mr1, rd1[27:0], a1[15:0], b1[15:0]}, 0);
        valid1 = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); @(negedge clk);
            if (rdy1 || wr1 || wait1) bad++;
        end
        chk(bad == 0, "arst_no_rdy", 64'(bad), 0);
        run_op(1'b0, 3'd0, 32'd3, 32'd5, 32'd15, "arst_mul");

        // Random against the reference model
        for (int n = 0; n < 48; n++) begin
            f  = 3'($urandom_range(0, 3));
            ra = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 5)] : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 5)] : $urandom;
            run_op(n % 6 == 5, f, ra, rb, refm(f, ra, rb), $sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
